// File: rtl/pipeline_hazard_ctrl.sv
//------------------------------------------------------------------------------
// Module      : pipeline_hazard_ctrl
// Description : Hazard controller for a five-stage in-order pipeline.
//               Produces the stage register enables, the bubble/flush
//               controls and the EX operand forwarding selects. Handles
//               memory back-pressure, branch redirects and load-use stalls,
//               and counts cycles in which the PC did not advance.
//
//   clk, rst                  : clock; synchronous active-high reset
//   id_rs1, id_rs2            : decode-stage source registers
//   ex_rs1, ex_rs2, ex_rd     : ID/EX source and destination registers
//   ex_is_load                : ID/EX instruction is a load
//   mem_rd, mem_regwrite      : EX/MEM destination / write enable
//   wb_rd, wb_regwrite        : MEM/WB destination / write enable
//   br_taken                  : EX resolved a taken branch or jump
//   imem_read, imem_resp      : fetch request / completion pulse
//   dmem_access, dmem_resp    : data request / completion pulse
//   *_load                    : stage register enables
//   if_id_flush, id_ex_flush  : zero incoming buffer contents
//   fwd_a, fwd_b              : 00 = regfile, 01 = WB, 10 = MEM
//   stall_cnt                 : saturating count of non-advancing PC cycles
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipeline_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_is_load,
  input  logic [4:0]  mem_rd,
  input  logic        mem_regwrite,
  input  logic [4:0]  wb_rd,
  input  logic        wb_regwrite,
  input  logic        br_taken,
  input  logic        imem_read,
  input  logic        imem_resp,
  input  logic        dmem_access,
  input  logic        dmem_resp,
  output logic        pc_load,
  output logic        if_id_load,
  output logic        id_ex_load,
  output logic        ex_mem_load,
  output logic        mem_wb_load,
  output logic        if_id_flush,
  output logic        id_ex_flush,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [31:0] stall_cnt
);

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

  state_t r_state;
  logic   r_imem_done;
  logic   r_dmem_done;

  logic   w_wait;
  logic   w_imem_ok;
  logic   w_dmem_ok;
  logic   w_ready;
  logic   w_hazard;

  // Completion memory is only meaningful while waiting; in RUN the done
  // bits are always clear, so the state qualifier just makes that explicit.
  assign w_wait    = (r_state == ST_MEM_WAIT);
  assign w_imem_ok = ~imem_read   | imem_resp | (w_wait & r_imem_done);
  assign w_dmem_ok = ~dmem_access | dmem_resp | (w_wait & r_dmem_done);
  assign w_ready   = w_imem_ok & w_dmem_ok;

  assign w_hazard  = ex_is_load & (ex_rd != 5'd0) &
                     ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  // Stage enables and flushes. Priority: memory stall > redirect > load-use.
  always_comb begin
    pc_load     = 1'b0;
    if_id_load  = 1'b0;
    id_ex_load  = 1'b0;
    ex_mem_load = 1'b0;
    mem_wb_load = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (!rst && w_ready) begin
      id_ex_load  = 1'b1;
      ex_mem_load = 1'b1;
      mem_wb_load = 1'b1;
      if (br_taken) begin
        // Redirect kills both younger instructions, so any load-use
        // dependency they carried is moot.
        pc_load     = 1'b1;
        if_id_load  = 1'b1;
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (w_hazard) begin
        // Hold PC and IF/ID, inject one bubble into ID/EX.
        id_ex_flush = 1'b1;
      end else begin
        pc_load     = 1'b1;
        if_id_load  = 1'b1;
      end
    end
  end

  // Forwarding: the younger producer in EX/MEM wins over MEM/WB.
  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (!rst) begin
      if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs1)
        fwd_a = 2'b10;
      else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs1)
        fwd_a = 2'b01;

      if (mem_regwrite && mem_rd != 5'd0 && mem_rd == ex_rs2)
        fwd_b = 2'b10;
      else if (wb_regwrite && wb_rd != 5'd0 && wb_rd == ex_rs2)
        fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_RUN;
      r_imem_done <= 1'b0;
      r_dmem_done <= 1'b0;
      stall_cnt   <= 32'd0;
    end else begin
      if (w_ready) begin
        // Advance cycle: consume both completions and resume.
        r_state     <= ST_RUN;
        r_imem_done <= 1'b0;
        r_dmem_done <= 1'b0;
      end else begin
        // A response only counts if its request is actually outstanding.
        r_state     <= ST_MEM_WAIT;
        r_imem_done <= r_imem_done | (imem_read & imem_resp);
        r_dmem_done <= r_dmem_done | (dmem_access & dmem_resp);
      end

      if (!pc_load && stall_cnt != C_CNT_MAX)
        stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

`default_nettype wire
